// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Load is legal when funct3 is a supported width and the address is naturally aligned.
  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~offset[0];
      F3_LW:         ok = (offset == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate narrow store data across every lane; the strobes select the live ones.
  function automatic logic [XLEN-1:0] store_align(input logic [2:0] f3, input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] d;
    case (f3)
      F3_SB:   d = {4{wdata[7:0]}};
      F3_SH:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_extractor.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module load_extractor
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      f3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (f3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: legality check, valid/ready data-memory port, load extension,
// core stall and per-access timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_f3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [3:0]      req_byte_enable,
  output logic            stall,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             legal;
  logic [XLEN-1:0]  ext_data;

  assign legal = req_write ? (req_byte_enable != 4'b0000)
                           : load_legal(req_f3, req_addr[1:0]);

  load_extractor u_load_extractor (
    .rdata  (mem_rdata),
    .offset (addr_q[1:0]),
    .f3     (f3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_write;
          f3_d    = req_f3;
          addr_d  = req_addr;
          wdata_d = req_write ? store_align(req_f3, req_wdata) : '0;
          wstrb_d = req_write ? req_byte_enable : 4'b0000;
          rdata_d = '0;
          err_d   = ~legal;
          cnt_d   = '0;
          state_d = legal ? S_REQ : S_RESP;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completed handshake wins over a timeout in the same cycle.
        if (mem_ready) begin
          state_d = we_q ? S_RESP : S_WAIT;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          rdata_d = ext_data;
          state_d = S_RESP;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and response flags decode from state; payloads come from registers.
  assign req_ready = (state_q == S_IDLE);
  assign stall     = (state_q == S_REQ) | (state_q == S_WAIT) | ((state_q == S_IDLE) & req_valid);
  assign mem_valid = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_error = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a cycle-count and data reference model.
module tb_load_store_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_byte_enable;
  logic        stall, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_f3          (req_f3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_byte_enable (req_byte_enable),
    .stall           (stall),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_error       (rsp_error),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_legal(input bit w, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [3:0] be);
    if (w) return be != 4'b0000;
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return addr[0] == 1'b0;
      3'd2:       return addr[1:0] == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] s;
    s = word >> (8 * int'(addr[1:0]));
    case (f3)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd4:    return {24'd0, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd5:    return {16'd0, s[15:0]};
      default: return word;
    endcase
  endfunction

  // One access from an idle DUT: rd = cycles mem_ready stays low, vd = extra cycles before rvalid.
  task automatic run_access(input bit w, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] word, input int rd, input int vd);
    bit legal, ok;
    int hs, rv, rsp, mv_end;
    logic [31:0] exp_wd, exp_rd;
    legal = model_legal(w, f3, addr, be);
    hs = 1 + rd;
    rv = 2 + rd + vd;
    if (!legal) begin
      ok = 1'b0; rsp = 1;
    end else if (w) begin
      ok = (hs <= T); rsp = ok ? hs + 1 : T + 1;
    end else begin
      ok = (hs <= T) && (rv <= T); rsp = ok ? rv + 1 : T + 1;
    end
    mv_end = !legal ? 0 : ((hs < T) ? hs : T);
    exp_wd = (f3 == 3'd0) ? {4{wdata[7:0]}} : (f3 == 3'd1) ? {2{wdata[15:0]}} : wdata;
    exp_rd = (legal && ok && !w) ? model_load(f3, addr, word) : 32'd0;

    req_valid = 1'b1; req_write = w; req_f3 = f3; req_addr = addr;
    req_wdata = wdata; req_byte_enable = be;
    #1;
    check("accept_ready", 32'(req_ready), 32'd1);
    check("accept_stall", 32'(stall), 32'd1);

    for (int c = 1; c <= rsp + 1; c++) begin
      @(posedge clk); #1;
      req_valid  = 1'b0;
      mem_ready  = legal && (c == hs);
      mem_rvalid = (legal && !w && (c == rv)) || (c == rsp + 1);
      mem_rdata  = (c == rv) ? word : $urandom();
      #1;
      check("mem_valid", 32'(mem_valid), 32'(c <= mv_end));
      check("rsp_valid", 32'(rsp_valid), 32'(c == rsp));
      check("stall", 32'(stall), 32'(c < rsp));
      if (c <= mv_end) begin
        check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("mem_we", 32'(mem_we), 32'(w));
        check("mem_wstrb", 32'(mem_wstrb), w ? 32'(be) : 32'd0);
        if (w) check("mem_wdata", mem_wdata, exp_wd);
      end
      if (c == rsp) begin
        check("rsp_error", 32'(rsp_error), 32'(!ok));
        check("rsp_rdata", rsp_rdata, exp_rd);
      end
      if (c == rsp + 1) check("idle_ready", 32'(req_ready), 32'd1);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    check("stale_rvalid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          w;
    int          rd, vd;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_f3 = '0; req_addr = '0;
    req_wdata = '0; req_byte_enable = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'd0, 0, 0);
    run_access(1'b0, 3'b000, 32'h0000_2002, 32'd0, 4'b0100, 32'h0080_0000, 0, 0);
    run_access(1'b0, 3'b100, 32'h0000_2002, 32'd0, 4'b0100, 32'h0080_0000, 0, 0);
    run_access(1'b0, 3'b101, 32'h0000_2002, 32'd0, 4'b1100, 32'hBEEF_1234, 1, 2);
    run_access(1'b0, 3'b001, 32'h0000_2001, 32'd0, 4'b0000, 32'hBEEF_1234, 0, 0);
    run_access(1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111, 32'd0, 3, 0);
    run_access(1'b0, 3'b010, 32'h0000_4000, 32'd0, 4'b1111, 32'h1234_5678, 0, 40);
    run_access(1'b1, 3'b010, 32'h0000_5000, 32'h1111_2222, 4'b1111, 32'd0, 40, 0);
    run_access(1'b1, 3'b010, 32'h0000_5002, 32'h1111_2222, 4'b0000, 32'd0, 0, 0);
    run_access(1'b0, 3'b011, 32'h0000_6000, 32'd0, 4'b1111, 32'd0, 0, 0);
    run_access(1'b0, 3'b010, 32'h0000_7000, 32'd0, 4'b1111, 32'hA5A5_5A5A, 0, T - 2);

    // Asynchronous reset while the load sits in WAIT.
    req_valid = 1'b1; req_write = 1'b0; req_f3 = 3'b010; req_addr = 32'h0000_8000;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    check("wait_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_mem_valid", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_access(1'b0, 3'b000, 32'h0000_9001, 32'd0, 4'b0010, 32'h0000_7F00, 0, 0);

    for (int i = 0; i < 150; i++) begin
      w    = 1'($urandom_range(0, 1));
      addr = $urandom();
      if (w) begin
        f3 = 3'($urandom_range(0, 2));
        case (f3)
          3'd0:    be = 4'b0001 << addr[1:0];
          3'd1:    be = addr[0] ? 4'b0000 : (4'b0011 << addr[1:0]);
          default: be = (addr[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
        if ($urandom_range(0, 7) == 0) be = 4'b0000;
      end else begin
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
        be = 4'b0000;
      end
      rd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      vd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
      run_access(w, f3, addr, $urandom(), be, $urandom(), rd, vd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
